// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Purpose  : Central controller for the 5-stage RV32I pipeline. It sequences
//            the core through BOOT -> RUN -> DRAIN -> HALTED. It generates the
//            PC / IF-ID enables and the IF/ID and ID/EX flushes for load-use
//            stalls, taken branches/jumps and halts. It also drives the
//            EX-stage operand forwarding selects.
// Ports    : clk, reset (sync, active-high)
//            instr_wr_en, start, halt_req       - sequencing controls
//            rs*_IFID, rs*_IDEX, rd_IDEX,
//            mem_rd_IDEX, pc_sel_EXIF           - hazard detection inputs
//            rd_EXMEM/reg_wr_en_EXMEM,
//            rd_WBID/reg_wr_en_WBID             - forwarding sources
//            pc_en, ifid_en, flush_IFID,
//            flush_IDEX                         - stall / flush controls
//            fwd_a, fwd_b                       - EX operand selects
//            core_state, halted                 - status
//            cycle_cnt, stall_cnt, flush_cnt    - only with HAZARD_PERF_CNT_EN
// Config   : define HAZARD_PERF_CNT_EN to add the performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instr_wr_en,
    input  logic             start,
    input  logic             halt_req,
    input  logic [4:0]       rs1_IFID,
    input  logic [4:0]       rs2_IFID,
    input  logic [4:0]       rs1_IDEX,
    input  logic [4:0]       rs2_IDEX,
    input  logic [4:0]       rd_IDEX,
    input  logic             mem_rd_IDEX,
    input  logic             pc_sel_EXIF,
    input  logic [4:0]       rd_EXMEM,
    input  logic             reg_wr_en_EXMEM,
    input  logic [4:0]       rd_WBID,
    input  logic             reg_wr_en_WBID,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             flush_IFID,
    output logic             flush_IDEX,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [1:0]       core_state,
`ifdef HAZARD_PERF_CNT_EN
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
`endif
    output logic             halted
);

    typedef enum logic [1:0] {
        ST_BOOT   = 2'b00,
        ST_RUN    = 2'b01,
        ST_DRAIN  = 2'b10,
        ST_HALTED = 2'b11
    } state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    state_e     state_q, state_d;
    logic [1:0] drain_cnt_q, drain_cnt_d;
    logic       load_use;
    logic       stall_evt;
    logic       flush_evt;

    // A load in EX whose destination feeds the instruction in ID. x0 is
    // never a real dependency.
    assign load_use = mem_rd_IDEX && (rd_IDEX != 5'd0) &&
                      ((rd_IDEX == rs1_IFID) || (rd_IDEX == rs2_IFID));

    // EX/MEM result is younger than WB data, so it wins when both match.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (reg_wr_en_EXMEM && (rd_EXMEM != 5'd0) && (rd_EXMEM == rs))
            return FWD_MEM;
        else if (reg_wr_en_WBID && (rd_WBID != 5'd0) && (rd_WBID == rs))
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

    assign fwd_a      = fwd_sel(rs1_IDEX);
    assign fwd_b      = fwd_sel(rs2_IDEX);
    assign core_state = state_q;
    assign halted     = (state_q == ST_HALTED);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_BOOT;
            drain_cnt_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    always_comb begin
        // Defaults give the frozen pipeline used by BOOT and HALTED.
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        flush_IFID  = 1'b1;
        flush_IDEX  = 1'b1;
        stall_evt   = 1'b0;
        flush_evt   = 1'b0;

        case (state_q)
            ST_BOOT: begin
                // Do not start while the instruction memory is being loaded.
                if (start && !instr_wr_en)
                    state_d = ST_RUN;
            end

            ST_RUN: begin
                if (pc_sel_EXIF) begin
                    // Redirect: the IF and ID instructions are wrong-path.
                    // A halt_req from ID is therefore ignored.
                    pc_en     = 1'b1;
                    ifid_en   = 1'b1;
                    flush_evt = 1'b1;
                end else if (load_use) begin
                    // Hold IF and ID, and insert one bubble into EX.
                    flush_IFID = 1'b0;
                    stall_evt  = 1'b1;
                end else if (halt_req) begin
                    // The halting instruction moves on into EX. Nothing
                    // younger may follow it.
                    state_d     = ST_DRAIN;
                    drain_cnt_d = 2'd0;
                    ifid_en     = 1'b1;
                    flush_IDEX  = 1'b0;
                end else begin
                    pc_en      = 1'b1;
                    ifid_en    = 1'b1;
                    flush_IFID = 1'b0;
                    flush_IDEX = 1'b0;
                end
            end

            ST_DRAIN: begin
                // Give the older instructions time to retire through WB.
                drain_cnt_d = drain_cnt_q + 2'd1;
                if (drain_cnt_d == 2'd3)
                    state_d = ST_HALTED;
            end

            default: begin
                // HALTED: only reset leaves this state.
            end
        endcase
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] cycle_cnt_q, stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt_q <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if ((state_q == ST_RUN) || (state_q == ST_DRAIN))
                cycle_cnt_q <= cycle_cnt_q + 1'b1;
            if (stall_evt)
                stall_cnt_q <= stall_cnt_q + 1'b1;
            if (flush_evt)
                flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end

    assign cycle_cnt = cycle_cnt_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Purpose  : Self-checking bench for pipe_hazard_ctrl. It uses table-driven
//            vectors in RUN and hand-written sequences for boot, halt/drain,
//            reset and the optional performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    localparam int CNT_W = 32;

    logic clk = 1'b0;
    logic reset, instr_wr_en, start, halt_req;
    logic [4:0] rs1_IFID, rs2_IFID, rs1_IDEX, rs2_IDEX, rd_IDEX;
    logic mem_rd_IDEX, pc_sel_EXIF;
    logic [4:0] rd_EXMEM, rd_WBID;
    logic reg_wr_en_EXMEM, reg_wr_en_WBID;
    logic pc_en, ifid_en, flush_IFID, flush_IDEX, halted;
    logic [1:0] fwd_a, fwd_b, core_state;
`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] cycle_cnt, stall_cnt, flush_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .instr_wr_en(instr_wr_en), .start(start),
        .halt_req(halt_req), .rs1_IFID(rs1_IFID), .rs2_IFID(rs2_IFID),
        .rs1_IDEX(rs1_IDEX), .rs2_IDEX(rs2_IDEX), .rd_IDEX(rd_IDEX),
        .mem_rd_IDEX(mem_rd_IDEX), .pc_sel_EXIF(pc_sel_EXIF),
        .rd_EXMEM(rd_EXMEM), .reg_wr_en_EXMEM(reg_wr_en_EXMEM),
        .rd_WBID(rd_WBID), .reg_wr_en_WBID(reg_wr_en_WBID),
        .pc_en(pc_en), .ifid_en(ifid_en), .flush_IFID(flush_IFID),
        .flush_IDEX(flush_IDEX), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .core_state(core_state),
`ifdef HAZARD_PERF_CNT_EN
        .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
`endif
        .halted(halted)
    );

    typedef struct {
        string      name;
        logic       halt;
        logic [4:0] rs1_ifid, rs2_ifid, rs1_idex, rs2_idex, rd_idex;
        logic       mem_rd, pc_sel;
        logic [4:0] rd_mem;
        logic       we_mem;
        logic [4:0] rd_wb;
        logic       we_wb;
        // expected
        logic       e_pc_en, e_ifid_en, e_fl_ifid, e_fl_idex;
        logic [1:0] e_fwd_a, e_fwd_b;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic check_ctl(input string name, input logic p, input logic i,
                             input logic fi, input logic fe);
        check({name, " ctl"}, {28'd0, pc_en, ifid_en, flush_IFID, flush_IDEX},
              {28'd0, p, i, fi, fe});
    endtask

    task automatic idle_inputs;
        instr_wr_en = 0; start = 0; halt_req = 0;
        rs1_IFID = 0; rs2_IFID = 0; rs1_IDEX = 0; rs2_IDEX = 0; rd_IDEX = 0;
        mem_rd_IDEX = 0; pc_sel_EXIF = 0;
        rd_EXMEM = 0; reg_wr_en_EXMEM = 0; rd_WBID = 0; reg_wr_en_WBID = 0;
    endtask

    // Reset, then move from BOOT to RUN. On return we are at a negedge in RUN.
    task automatic reset_and_run;
        @(negedge clk); idle_inputs(); reset = 1;
        @(negedge clk); reset = 0; start = 1;
        @(negedge clk); start = 0;
    endtask

    function automatic vec_t mk(input string nm, input logic h,
        input logic [4:0] r1i, input logic [4:0] r2i, input logic [4:0] r1e,
        input logic [4:0] r2e, input logic [4:0] rde, input logic mr, input logic ps,
        input logic [4:0] rdm, input logic wm, input logic [4:0] rdw, input logic ww,
        input logic p, input logic i, input logic fi, input logic fe,
        input logic [1:0] fa, input logic [1:0] fb);
        vec_t v;
        v.name = nm; v.halt = h; v.rs1_ifid = r1i; v.rs2_ifid = r2i;
        v.rs1_idex = r1e; v.rs2_idex = r2e; v.rd_idex = rde; v.mem_rd = mr;
        v.pc_sel = ps; v.rd_mem = rdm; v.we_mem = wm; v.rd_wb = rdw; v.we_wb = ww;
        v.e_pc_en = p; v.e_ifid_en = i; v.e_fl_ifid = fi; v.e_fl_idex = fe;
        v.e_fwd_a = fa; v.e_fwd_b = fb;
        return v;
    endfunction

    initial begin
        //             name          h  r1i r2i r1e r2e rde mr ps rdm wm rdw ww  p  i fi fe fa     fb
        vecs[0]  = mk("run_idle",    0, 0,  0,  0,  0,  0,  0, 0, 0,  0, 0,  0,  1, 1, 0, 0, 2'b00, 2'b00);
        vecs[1]  = mk("lu_rs2",      0, 1,  5,  0,  0,  5,  1, 0, 0,  0, 0,  0,  0, 0, 0, 1, 2'b00, 2'b00);
        vecs[2]  = mk("lu_rd0",      0, 0,  0,  0,  0,  0,  1, 0, 0,  0, 0,  0,  1, 1, 0, 0, 2'b00, 2'b00);
        vecs[3]  = mk("lu_rs1",      0, 9,  2,  0,  0,  9,  1, 0, 0,  0, 0,  0,  0, 0, 0, 1, 2'b00, 2'b00);
        vecs[4]  = mk("no_load",     0, 9,  2,  0,  0,  9,  0, 0, 0,  0, 0,  0,  1, 1, 0, 0, 2'b00, 2'b00);
        vecs[5]  = mk("fwd_mem_pri", 0, 0,  0,  7,  0,  0,  0, 0, 7,  1, 7,  1,  1, 1, 0, 0, 2'b01, 2'b00);
        vecs[6]  = mk("fwd_wb",      0, 0,  0,  7,  0,  0,  0, 0, 7,  0, 7,  1,  1, 1, 0, 0, 2'b10, 2'b00);
        vecs[7]  = mk("fwd_x0",      0, 0,  0,  3,  0,  0,  0, 0, 3,  1, 0,  1,  1, 1, 0, 0, 2'b01, 2'b00);
        vecs[8]  = mk("fwd_ab",      0, 0,  0,  4,  12, 0,  0, 0, 12, 1, 4,  1,  1, 1, 0, 0, 2'b10, 2'b01);
        vecs[9]  = mk("branch",      0, 0,  0,  0,  0,  0,  0, 1, 0,  0, 0,  0,  1, 1, 1, 1, 2'b00, 2'b00);
        vecs[10] = mk("br_halt_lu",  1, 5,  5,  0,  0,  5,  1, 1, 0,  0, 0,  0,  1, 1, 1, 1, 2'b00, 2'b00);

        idle_inputs();
        reset = 1;

        // ---- Reset state ----
        @(negedge clk);
        check("rst_state", {30'd0, core_state}, 32'd0);
        check_ctl("rst", 0, 0, 1, 1);
        check("rst_fwd", {28'd0, fwd_a, fwd_b}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);

        // ---- Boot: start is ignored while the instruction memory loads ----
        reset = 0; instr_wr_en = 1; start = 1;
        @(negedge clk);
        check("boot_hold", {30'd0, core_state}, 32'd0);
        instr_wr_en = 0;
        @(negedge clk);
        start = 0;
        check("boot_run", {30'd0, core_state}, 32'd1);
        #1 check("boot_pc_en", {31'd0, pc_en}, 32'd1);

        // ---- Table vectors (combinational, in RUN) ----
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            halt_req = vecs[k].halt;
            rs1_IFID = vecs[k].rs1_ifid; rs2_IFID = vecs[k].rs2_ifid;
            rs1_IDEX = vecs[k].rs1_idex; rs2_IDEX = vecs[k].rs2_idex;
            rd_IDEX = vecs[k].rd_idex; mem_rd_IDEX = vecs[k].mem_rd;
            pc_sel_EXIF = vecs[k].pc_sel;
            rd_EXMEM = vecs[k].rd_mem; reg_wr_en_EXMEM = vecs[k].we_mem;
            rd_WBID = vecs[k].rd_wb; reg_wr_en_WBID = vecs[k].we_wb;
            #1;
            check_ctl(vecs[k].name, vecs[k].e_pc_en, vecs[k].e_ifid_en,
                      vecs[k].e_fl_ifid, vecs[k].e_fl_idex);
            check({vecs[k].name, " fwd"}, {28'd0, fwd_a, fwd_b},
                  {28'd0, vecs[k].e_fwd_a, vecs[k].e_fwd_b});
        end
        // The branch wins over halt and stall, so the core stays in RUN.
        @(negedge clk);
        check("br_halt_state", {30'd0, core_state}, 32'd1);
        idle_inputs();

        // ---- Halt: accepted in cycle N, halted at N+4 ----
        @(negedge clk);
        halt_req = 1;
        #1 check_ctl("halt_acc", 0, 1, 1, 0);
        @(negedge clk);                       // N+1
        halt_req = 0;
        check("drain_state", {30'd0, core_state}, 32'd2);
        @(negedge clk);                       // N+2
        pc_sel_EXIF = 1;
        #1 check_ctl("drain_br_ign", 0, 0, 1, 1);
        @(negedge clk);                       // N+3
        pc_sel_EXIF = 0;
        check("not_yet_halted", {31'd0, halted}, 32'd0);
        @(negedge clk);                       // N+4
        check("halted", {31'd0, halted}, 32'd1);
        check("halted_state", {30'd0, core_state}, 32'd3);
        check_ctl("halted", 0, 0, 1, 1);
        start = 1;
        @(negedge clk);
        start = 0;
        check("halted_sticky", {30'd0, core_state}, 32'd3);
        reset = 1;
        @(negedge clk);
        reset = 0;
        check("halt_rst_boot", {30'd0, core_state}, 32'd0);
        check("halt_rst_flag", {31'd0, halted}, 32'd0);

        // ---- Reset mid-drain aborts the drain; a later halt takes 4 again ----
        reset_and_run();
        halt_req = 1;
        @(negedge clk); halt_req = 0;
        @(negedge clk); reset = 1;
        @(negedge clk); reset = 0;
        check("drain_abort", {30'd0, core_state}, 32'd0);
        start = 1;
        @(negedge clk); start = 0;
        halt_req = 1;
        @(negedge clk); halt_req = 0;
        @(negedge clk);
        @(negedge clk);
        check("redrain_n3", {30'd0, core_state}, 32'd2);
        @(negedge clk);
        check("redrain_n4", {30'd0, core_state}, 32'd3);

`ifdef HAZARD_PERF_CNT_EN
        // ---- Performance counters: 20 RUN cycles, 3 stalls, 2 branches ----
        reset_and_run();
        for (int c = 0; c < 20; c++) begin
            idle_inputs();
            if (c == 2 || c == 5 || c == 8) begin
                mem_rd_IDEX = 1; rd_IDEX = 6; rs1_IFID = 6;
            end
            if (c == 11 || c == 15) pc_sel_EXIF = 1;
            @(posedge clk);
            #1;
        end
        idle_inputs();
        check("cycle_cnt", cycle_cnt, 32'd20);
        check("stall_cnt", stall_cnt, 32'd3);
        check("flush_cnt", flush_cnt, 32'd2);
        @(negedge clk); reset = 1;
        @(negedge clk); reset = 0;
        check("cnt_rst", cycle_cnt | stall_cnt | flush_cnt, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
